// File: rtl/clock_ctrl.sv
// Run-control front end for the system clock gater: button conditioning,
// reset stretching and a run/halt/single-step state machine.
module clock_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int RST_CYCLES      = 8,
    parameter int STEP_CYCLES     = 1,
    parameter bit START_RUN       = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn_rst,
    input  logic i_btn_run,
    input  logic i_btn_step,
    input  logic i_halt,
    output logic o_rst,
    output logic o_pause,
    output logic o_running
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SW = $clog2(RST_CYCLES + 1);
    localparam int PW = $clog2(STEP_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_RESET,
        S_HALT,
        S_RUN,
        S_STEP
    } state_t;

    // bit 0 = rst, bit 1 = run, bit 2 = step
    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    lvl;
    logic [2:0]    flip;
    logic [DW-1:0] db_cnt [3];
    logic          run_p;
    logic          step_p;

    always_comb begin
        flip = '0;
        for (int i = 0; i < 3; i++) begin
            flip[i] = (sync2[i] != lvl[i]) && (db_cnt[i] == DB_LAST);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            sync1  <= '0;
            sync2  <= '0;
            lvl    <= '0;
            run_p  <= 1'b0;
            step_p <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1  <= {i_btn_step, i_btn_run, i_btn_rst};
            sync2  <= sync1;
            lvl    <= lvl ^ flip;
            run_p  <= flip[1] & ~lvl[1];
            step_p <= flip[2] & ~lvl[2];
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == lvl[i] || flip[i]) begin
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DW'(1);
                end
            end
        end
    end

    logic [SW-1:0] st_cnt;
    logic          rst_nxt;

    assign rst_nxt = lvl[0] | (st_cnt > SW'(1));

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            st_cnt <= SW'(RST_CYCLES);
        end else if (lvl[0]) begin
            st_cnt <= SW'(RST_CYCLES);
        end else if (st_cnt != '0) begin
            st_cnt <= st_cnt - SW'(1);
        end
    end

    state_t        state;
    state_t        nstate;
    logic [PW-1:0] step_cnt;
    logic [PW-1:0] step_nxt;

    // Forcing on the next o_rst keeps o_pause high on the edge o_rst rises.
    always_comb begin
        nstate   = state;
        step_nxt = step_cnt;
        if (o_rst || rst_nxt) begin
            nstate = S_RESET;
        end else begin
            case (state)
                S_RESET: nstate = START_RUN ? S_RUN : S_HALT;
                S_HALT: begin
                    if (run_p) begin
                        nstate = S_RUN;
                    end else if (step_p) begin
                        nstate   = S_STEP;
                        step_nxt = PW'(STEP_CYCLES);
                    end
                end
                S_RUN: begin
                    if (i_halt || run_p) nstate = S_HALT;
                end
                S_STEP: begin
                    if (i_halt || step_cnt <= PW'(1)) begin
                        nstate = S_HALT;
                    end else begin
                        step_nxt = step_cnt - PW'(1);
                    end
                end
                default: nstate = S_RESET;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state     <= S_RESET;
            step_cnt  <= '0;
            o_rst     <= 1'b1;
            o_pause   <= 1'b1;
            o_running <= 1'b0;
        end else begin
            state     <= nstate;
            step_cnt  <= step_nxt;
            o_rst     <= rst_nxt;
            o_pause   <= (nstate == S_RESET) || (nstate == S_HALT);
            o_running <= (nstate == S_RUN) || (nstate == S_STEP);
        end
    end

endmodule

// File: tb/tb_clock_ctrl.sv
// Directed bench for clock_ctrl: expected {o_rst,o_pause,o_running}
// per cycle are queued when stimulus is applied and checked per cycle.
module tb_clock_ctrl;

    localparam int DB  = 4;
    localparam int RC  = 8;
    localparam int SC  = 3;
    localparam int LAT = 2 + DB + 1;

    localparam logic [2:0] E_RST  = 3'b110;
    localparam logic [2:0] E_HALT = 3'b010;
    localparam logic [2:0] E_RUN  = 3'b001;

    logic clk = 1'b0;
    logic i_rst = 1'b1;
    logic i_btn_rst = 1'b0;
    logic i_btn_run = 1'b0;
    logic i_btn_step = 1'b0;
    logic i_halt = 1'b0;
    logic o_rst;
    logic o_pause;
    logic o_running;

    typedef struct {
        int         cyc;
        logic [2:0] v;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_assert = 0;
    int   n_fail = 0;

    clock_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .RST_CYCLES(RC),
        .STEP_CYCLES(SC),
        .START_RUN(1'b0)
    ) dut (
        .i_clk(clk),
        .i_rst(i_rst),
        .i_btn_rst(i_btn_rst),
        .i_btn_run(i_btn_run),
        .i_btn_step(i_btn_step),
        .i_halt(i_halt),
        .o_rst(o_rst),
        .o_pause(o_pause),
        .o_running(o_running)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [2:0] obs, logic [2:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed rst/pause/run=%b expected %b",
                   tag, cyc, obs, expv);
        end
    endtask

    task automatic expw(string tag, int a, int b, logic [2:0] v);
        exp_t e;
        for (int c = a; c <= b; c++) begin
            e.cyc = cyc + c;
            e.v   = v;
            e.tag = tag;
            sb.push_back(e);
        end
    endtask

    task automatic tick(int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc == cyc) begin
                    chk(sb[i].tag, {o_rst, o_pause, o_running}, sb[i].v);
                    sb.delete(i);
                end
            end
        end
    endtask

    initial begin
        #2 i_rst = 1'b0;
        #1 chk("reset_async", {o_rst, o_pause, o_running}, E_RST);
        expw("reset_hold", 1, 3, E_RST);
        tick(3);

        i_rst = 1'b1;
        expw("stretch_por", 1, RC - 1, E_RST);
        expw("halt_after_por", RC, RC + 4, E_HALT);
        tick(RC + 4);

        i_btn_run = 1'b1;
        expw("glitch_ignored", 1, 14, E_HALT);
        tick(3);
        i_btn_run = 1'b0;
        tick(11);

        i_btn_run = 1'b1;
        expw("run_latency", 1, LAT - 1, E_HALT);
        expw("run_entered", LAT, 18, E_RUN);
        tick(10);
        i_btn_run = 1'b0;
        tick(8);

        i_halt = 1'b1;
        expw("halt_in_run", 1, 3, E_HALT);
        tick(1);
        i_halt = 1'b0;
        tick(2);

        i_btn_step = 1'b1;
        expw("step_wait", 1, LAT - 1, E_HALT);
        expw("step_low", LAT, LAT + SC - 1, E_RUN);
        expw("step_held_once", LAT + SC, 22, E_HALT);
        tick(14);
        i_btn_step = 1'b0;
        tick(8);

        i_btn_step = 1'b1;
        expw("step2_wait", 1, LAT - 1, E_HALT);
        expw("step2_low", LAT, LAT + SC - 1, E_RUN);
        expw("step2_done", LAT + SC, 13, E_HALT);
        tick(13);
        i_btn_step = 1'b0;
        tick(8);

        i_btn_step = 1'b1;
        expw("stephalt_wait", 1, LAT - 1, E_HALT);
        expw("stephalt_low", LAT, LAT + 1, E_RUN);
        expw("stephalt_cut", LAT + 2, 17, E_HALT);
        tick(LAT + 1);
        i_halt = 1'b1;
        tick(1);
        i_halt = 1'b0;
        i_btn_step = 1'b0;
        tick(17 - LAT - 2);

        i_btn_run  = 1'b1;
        i_btn_step = 1'b1;
        expw("both_wait", 1, LAT - 1, E_HALT);
        expw("both_run_wins", LAT, 20, E_RUN);
        tick(10);
        i_btn_run  = 1'b0;
        i_btn_step = 1'b0;
        tick(10);

        // level rises at +6, o_rst at +7; release at +20 -> level falls +26
        i_btn_rst = 1'b1;
        expw("btnrst_wait", 1, LAT - 1, E_RUN);
        expw("btnrst_hold", LAT, 26 + RC - 1, E_RST);
        expw("btnrst_halt", 26 + RC, 26 + RC + 4, E_HALT);
        tick(20);
        i_btn_rst = 1'b0;
        tick(26 + RC + 4 - 20);

        // re-press lands while stretch count is 3; fall moves to +39
        i_btn_rst = 1'b1;
        expw("repress_wait", 1, LAT - 1, E_HALT);
        expw("repress_hold", LAT, 38, E_RST);
        expw("repress_halt", 39, 42, E_HALT);
        tick(10);
        i_btn_rst = 1'b0;
        tick(5);
        i_btn_rst = 1'b1;
        tick(10);
        i_btn_rst = 1'b0;
        tick(42 - 25);

        i_btn_step = 1'b1;
        expw("async_pre_wait", 1, LAT - 1, E_HALT);
        expw("async_pre_step", LAT, LAT, E_RUN);
        tick(LAT);
        #2 i_rst = 1'b0;
        #1 chk("reset_async_step", {o_rst, o_pause, o_running}, E_RST);
        i_btn_step = 1'b0;
        tick(2);
        i_rst = 1'b1;
        expw("stretch_again", 1, RC - 1, E_RST);
        expw("halt_again", RC, RC + 2, E_HALT);
        tick(RC + 2);

        n_assert++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL sb_drain observed %0d pending expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
